// File: rtl/can_rx_frame.sv
// CAN 2.0A receive frame engine: destuffs the sampled bus, parses standard
// data/remote frames, checks CRC-15 and frame form, drives ACK and error flags.
module can_rx_frame #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter int unsigned ID_W     = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bit_tick,
  input  logic            rx_bit,
  input  logic            ack_en,
  input  logic            passive,
  output logic            tx_bit,
  output logic            busy,
  output logic            frame_valid,
  output logic [ID_W-1:0] rx_id,
  output logic            rx_rtr,
  output logic [3:0]      rx_dlc,
  output logic [63:0]     rx_data,
  output logic            err_stuff,
  output logic            err_crc,
  output logic            err_form
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RUN_W  = 3;
  localparam int unsigned CRC_W  = 15;
  localparam int unsigned DATA_W = 64;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(10);
  localparam logic [CNT_W-1:0] RTR_POS   = CNT_W'(ID_W);
  localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(6);
  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(5);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(5);

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERRFLAG
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               prev_q, prev_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   crc_rx_q, crc_rx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rtr_q, rtr_d;
  logic [3:0]         dlc_q, dlc_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               tx_bit_q, tx_bit_d;
  logic               busy_q, busy_d;
  logic               frame_valid_q, frame_valid_d;
  logic               err_stuff_q, err_stuff_d;
  logic               err_crc_q, err_crc_d;
  logic               err_form_q, err_form_d;
  logic [ID_W-1:0]    rx_id_q, rx_id_d;
  logic               rx_rtr_q, rx_rtr_d;
  logic [3:0]         rx_dlc_q, rx_dlc_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;

  logic               in_stuff;
  logic               take_bit;
  logic               go_err;
  logic [CNT_W:0]     data_len;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic nxt;
    nxt = b ^ c[CRC_W-1];
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (nxt ? CRC_POLY : CRC_W'(0));
  endfunction

  // DLC values above 8 still carry 8 bytes
  assign data_len = (dlc_q > 4'd8) ? 7'd64 : {dlc_q, 3'b000};
  assign in_stuff = (state_q == S_ARB) || (state_q == S_CTRL) ||
                    (state_q == S_DATA) || (state_q == S_CRC);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    run_d         = run_q;
    prev_d        = prev_q;
    crc_d         = crc_q;
    crc_rx_d      = crc_rx_q;
    id_d          = id_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    tx_bit_d      = tx_bit_q;
    busy_d        = busy_q;
    frame_valid_d = 1'b0;
    err_stuff_d   = 1'b0;
    err_crc_d     = 1'b0;
    err_form_d    = 1'b0;
    rx_id_d       = rx_id_q;
    rx_rtr_d      = rx_rtr_q;
    rx_dlc_d      = rx_dlc_q;
    rx_data_d     = rx_data_q;
    take_bit      = 1'b1;
    go_err        = 1'b0;

    if (bit_tick) begin
      // Destuffing: a stuff slot follows every run of 5 equal bits
      if (in_stuff) begin
        if (run_q == RUN_MAX) begin
          take_bit = 1'b0;
          if (rx_bit == prev_q) begin
            err_stuff_d = 1'b1;
            go_err      = 1'b1;
          end else begin
            prev_d = rx_bit;
            run_d  = RUN_W'(1);
          end
        end else if (rx_bit == prev_q) begin
          run_d = run_q + RUN_W'(1);
        end else begin
          run_d  = RUN_W'(1);
          prev_d = rx_bit;
        end
      end

      if (take_bit) begin
        case (state_q)
          S_WAIT_IDLE: begin
            if (!rx_bit) begin
              cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_IDLE: begin
            if (!rx_bit) begin
              state_d = S_ARB;
              cnt_d   = '0;
              busy_d  = 1'b1;
              run_d   = RUN_W'(1);
              prev_d  = 1'b0;
              crc_d   = crc_step(CRC_W'(0), rx_bit);
              id_d    = '0;
              rtr_d   = 1'b0;
              dlc_d   = '0;
              data_d  = '0;
            end
          end
          S_ARB: begin
            crc_d = crc_step(crc_q, rx_bit);
            if (cnt_q == RTR_POS) begin
              rtr_d   = rx_bit;
              cnt_d   = '0;
              state_d = S_CTRL;
            end else begin
              id_d  = {id_q[ID_W-2:0], rx_bit};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_CTRL: begin
            crc_d = crc_step(crc_q, rx_bit);
            if (cnt_q >= CNT_W'(2)) dlc_d = {dlc_q[2:0], rx_bit};
            if ((cnt_q == '0) && rx_bit) begin
              err_form_d = 1'b1;
              go_err     = 1'b1;
            end else if (cnt_q == CTRL_LAST) begin
              cnt_d   = '0;
              state_d = (rtr_q || ({dlc_q[2:0], rx_bit} == 4'd0)) ? S_CRC : S_DATA;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            crc_d          = crc_step(crc_q, rx_bit);
            data_d[~cnt_q] = rx_bit;
            if ({1'b0, cnt_q} == data_len - 7'd1) begin
              cnt_d   = '0;
              state_d = S_CRC;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[CRC_W-2:0], rx_bit};
            if (cnt_q == CRC_LAST) begin
              cnt_d   = '0;
              state_d = S_CRC_DEL;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_CRC_DEL: begin
            if (!rx_bit) begin
              err_form_d = 1'b1;
              go_err     = 1'b1;
            end else if (crc_rx_q != crc_q) begin
              err_crc_d = 1'b1;
              go_err    = 1'b1;
            end else begin
              tx_bit_d = ~ack_en;
              state_d  = S_ACK;
            end
          end
          S_ACK: begin
            tx_bit_d = 1'b1;
            state_d  = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!rx_bit) begin
              err_form_d = 1'b1;
              go_err     = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = S_EOF;
            end
          end
          S_EOF: begin
            if (!rx_bit) begin
              err_form_d = 1'b1;
              go_err     = 1'b1;
            end else if (cnt_q == EOF_LAST) begin
              rx_id_d       = id_q;
              rx_rtr_d      = rtr_q;
              rx_dlc_d      = dlc_q;
              rx_data_d     = data_q;
              frame_valid_d = 1'b1;
              busy_d        = 1'b0;
              cnt_d         = '0;
              state_d       = S_WAIT_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_ERRFLAG: begin
            if (cnt_q == ERR_LAST) begin
              tx_bit_d = 1'b1;
              busy_d   = 1'b0;
              cnt_d    = '0;
              state_d  = S_WAIT_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = S_WAIT_IDLE;
          end
        endcase
      end

      // Every error hands the bus to a 6-bit error flag
      if (go_err) begin
        state_d  = S_ERRFLAG;
        cnt_d    = '0;
        tx_bit_d = passive;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_IDLE;
      cnt_q         <= '0;
      run_q         <= '0;
      prev_q        <= 1'b1;
      crc_q         <= '0;
      crc_rx_q      <= '0;
      id_q          <= '0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      data_q        <= '0;
      tx_bit_q      <= 1'b1;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      err_stuff_q   <= 1'b0;
      err_crc_q     <= 1'b0;
      err_form_q    <= 1'b0;
      rx_id_q       <= '0;
      rx_rtr_q      <= 1'b0;
      rx_dlc_q      <= '0;
      rx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      run_q         <= run_d;
      prev_q        <= prev_d;
      crc_q         <= crc_d;
      crc_rx_q      <= crc_rx_d;
      id_q          <= id_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      tx_bit_q      <= tx_bit_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      err_stuff_q   <= err_stuff_d;
      err_crc_q     <= err_crc_d;
      err_form_q    <= err_form_d;
      rx_id_q       <= rx_id_d;
      rx_rtr_q      <= rx_rtr_d;
      rx_dlc_q      <= rx_dlc_d;
      rx_data_q     <= rx_data_d;
    end
  end

  assign tx_bit      = tx_bit_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign err_stuff   = err_stuff_q;
  assign err_crc     = err_crc_q;
  assign err_form    = err_form_q;
  assign rx_id       = rx_id_q;
  assign rx_rtr      = rx_rtr_q;
  assign rx_dlc      = rx_dlc_q;
  assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Bench for can_rx_frame: frames are built from fields, CRC'd and stuffed by a
// reference encoder; outputs are logged per bit and compared to expectations.
module tb_can_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_tick = 1'b0;
  logic        rx_bit = 1'b1;
  logic        ack_en = 1'b0;
  logic        passive = 1'b0;
  logic        tx_bit, busy, frame_valid;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        err_stuff, err_crc, err_form;

  can_rx_frame #(.CRC_POLY(15'h4599), .ID_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .rx_bit(rx_bit),
    .ack_en(ack_en), .passive(passive), .tx_bit(tx_bit), .busy(busy),
    .frame_valid(frame_valid), .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .err_stuff(err_stuff), .err_crc(err_crc), .err_form(err_form)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  bit   stream[$];
  int   stuff_pos[$];
  int   crc_del_idx, eof_idx, last_idx;
  logic drv_log[$], fv_log[$], es_log[$], ec_log[$], ef_log[$], busy_log[$];

  logic [10:0] exp_id;
  logic        exp_rtr;
  logic [3:0]  exp_dlc;
  logic [63:0] exp_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: fields -> CRC -> bit stuffing -> tail fields
  task automatic make_frame(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input int flip);
    bit raw[$];
    logic [14:0] c;
    bit nxt, last;
    int run, nb;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
    c = 15'h0;
    foreach (raw[i]) begin
      nxt = raw[i] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    if (flip >= 0) raw[flip] = ~raw[flip];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    stream = {};
    stuff_pos = {};
    last = ~raw[0];
    run = 0;
    foreach (raw[i]) begin
      stream.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin run = 1; last = raw[i]; end
      if (run == 5 && i < raw.size() - 1) begin
        stuff_pos.push_back(stream.size());
        stream.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
    crc_del_idx = stream.size();
    stream.push_back(1'b1);
    stream.push_back(1'b0);
    stream.push_back(1'b1);
    eof_idx = stream.size();
    repeat (7) stream.push_back(1'b1);
    last_idx = stream.size() - 1;
  endtask

  task automatic send_bit(input bit b);
    rx_bit = b;
    @(negedge clk);
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    drv_log.push_back(~tx_bit);
    fv_log.push_back(frame_valid);
    es_log.push_back(err_stuff);
    ec_log.push_back(err_crc);
    ef_log.push_back(err_form);
    busy_log.push_back(busy);
    @(negedge clk);
  endtask

  task automatic run_stream(input int trail);
    drv_log = {}; fv_log = {}; es_log = {}; ec_log = {}; ef_log = {}; busy_log = {};
    foreach (stream[i]) send_bit(stream[i]);
    repeat (trail) send_bit(1'b1);
  endtask

  function automatic void scan(input logic l[$], output int cnt, output int first);
    cnt = 0;
    first = -1;
    foreach (l[i]) if (l[i] === 1'b1) begin
      if (first < 0) first = i;
      cnt++;
    end
  endfunction

  task automatic check_rx(input string tag);
    check_val({tag, "_rx_id"},   64'(rx_id),   64'(exp_id));
    check_val({tag, "_rx_rtr"},  64'(rx_rtr),  64'(exp_rtr));
    check_val({tag, "_rx_dlc"},  64'(rx_dlc),  64'(exp_dlc));
    check_val({tag, "_rx_data"}, rx_data, exp_data);
  endtask

  task automatic check_valid(input string tag, input logic [10:0] id, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input bit ack);
    int c, f, c2, f2, c3, f3, nb;
    scan(fv_log, c, f);
    check_val({tag, "_fv_cnt"}, 64'(c), 64'(1));
    check_val({tag, "_fv_pos"}, 64'(f), 64'(last_idx));
    scan(es_log, c, f); scan(ec_log, c2, f2); scan(ef_log, c3, f3);
    check_val({tag, "_err_cnt"}, 64'(c + c2 + c3), 64'(0));
    scan(drv_log, c, f);
    check_val({tag, "_ack_cnt"}, 64'(c), ack ? 64'(1) : 64'(0));
    check_val({tag, "_ack_pos"}, 64'(f), ack ? 64'(crc_del_idx) : 64'(-1));
    check_val({tag, "_busy_sof"}, 64'(busy_log[0]), 64'(1));
    check_val({tag, "_busy_end"}, 64'(busy_log[last_idx]), 64'(0));
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    exp_id = id; exp_rtr = rtr; exp_dlc = dlc; exp_data = 64'h0;
    for (int k = 0; k < nb * 8; k++) exp_data[63 - k] = data[63 - k];
    check_rx(tag);
  endtask

  // kind: 0 stuff, 1 crc, 2 form
  task automatic check_error(input string tag, input int kind, input int e_idx, input bit pas);
    int c, f;
    scan(es_log, c, f);
    check_val({tag, "_stuff_cnt"}, 64'(c), (kind == 0) ? 64'(1) : 64'(0));
    if (kind == 0) check_val({tag, "_stuff_pos"}, 64'(f), 64'(e_idx));
    scan(ec_log, c, f);
    check_val({tag, "_crc_cnt"}, 64'(c), (kind == 1) ? 64'(1) : 64'(0));
    if (kind == 1) check_val({tag, "_crc_pos"}, 64'(f), 64'(e_idx));
    scan(ef_log, c, f);
    check_val({tag, "_form_cnt"}, 64'(c), (kind == 2) ? 64'(1) : 64'(0));
    if (kind == 2) check_val({tag, "_form_pos"}, 64'(f), 64'(e_idx));
    scan(fv_log, c, f);
    check_val({tag, "_fv_cnt"}, 64'(c), 64'(0));
    scan(drv_log, c, f);
    check_val({tag, "_flag_len"}, 64'(c), pas ? 64'(0) : 64'(6));
    check_val({tag, "_flag_pos"}, 64'(f), pas ? 64'(-1) : 64'(e_idx));
    check_rx(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tx"},    64'(tx_bit), 64'(1));
    check_val({tag, "_busy"},  64'(busy), 64'(0));
    check_val({tag, "_pulses"}, 64'({frame_valid, err_stuff, err_crc, err_form}), 64'(0));
    exp_id = 11'h0; exp_rtr = 1'b0; exp_dlc = 4'h0; exp_data = 64'h0;
    check_rx(tag);
  endtask

  initial begin
    logic [10:0] rid;
    bit          rrtr, rack;
    logic [3:0]  rdlc;
    logic [63:0] rdata;
    int c, f, p;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // SOF after only 10 recessive bits must be ignored
    repeat (10) send_bit(1'b1);
    ack_en = 1'b1;
    make_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    run_stream(14);
    scan(busy_log, c, f);
    check_val("idle_busy", 64'(c), 64'(0));
    scan(fv_log, c, f);
    check_val("idle_fv", 64'(c), 64'(0));

    make_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    run_stream(14);
    check_valid("one_byte", 11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b1);

    make_frame(11'h000, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    run_stream(14);
    check_valid("stuff_ok", 11'h000, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Turn the first stuff bit into a 6th equal bit
    make_frame(11'h000, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    p = stuff_pos[0];
    stream[p] = ~stream[p];
    run_stream(14);
    check_error("stuff_err", 0, p, 1'b0);

    // Raw index 21 is the third data bit
    make_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 21);
    run_stream(14);
    check_error("crc_err", 1, crc_del_idx, 1'b0);

    make_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 21);
    stream[crc_del_idx] = 1'b0;
    run_stream(14);
    check_error("crcdel_form", 2, crc_del_idx, 1'b0);

    passive = 1'b1;
    ack_en = 1'b0;
    make_frame(11'h7FF, 1'b1, 4'd4, 64'h0, -1);
    stream[eof_idx + 2] = 1'b0;
    run_stream(14);
    check_error("eof_form", 2, eof_idx + 2, 1'b1);

    for (int n = 0; n < 20; n++) begin
      rid   = 11'($urandom_range(0, 2047));
      rrtr  = ($urandom_range(0, 3) == 0);
      rdlc  = 4'($urandom_range(0, 15));
      rdata = {$urandom, $urandom};
      rack  = 1'($urandom_range(0, 1));
      ack_en  = rack;
      passive = 1'($urandom_range(0, 1));
      make_frame(rid, rrtr, rdlc, rdata, -1);
      run_stream(14);
      check_valid($sformatf("rand%0d", n), rid, rrtr, rdlc, rdata, rack);
    end

    // Reset in the middle of the data field
    ack_en = 1'b1;
    passive = 1'b0;
    make_frame(11'h2A5, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, -1);
    for (int i = 0; i < 30; i++) send_bit(stream[i]);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (11) send_bit(1'b1);
    make_frame(11'h555, 1'b0, 4'd3, 64'hC0FF_EE00_0000_0000, -1);
    run_stream(14);
    check_valid("post_rst", 11'h555, 1'b0, 4'd3, 64'hC0FF_EE00_0000_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/can_rx_frame.md
# can_rx_frame

CAN 2.0A receive frame engine. It samples the wired-AND bus once per bit time, removes stuff bits, and parses standard data and remote frames: 11-bit ID, RTR, DLC and up to 8 data bytes. It checks the CRC-15 and frame form, drives the ACK slot, and signals active or passive error flags. It is the receive counterpart of the node's transmit/CRC-generation path, and its `tx_bit` output feeds one leg of the bus AND.

## Interface
- `CRC_POLY`, default 15'h4599: CRC-15 generator polynomial, with the x^15 term implicit.
- `ID_W`, default 11: identifier width. Only 11 is supported.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bit_tick` in 1: one-cycle sample-point strobe, one per bus bit. At most one strobe per 2 clk.
- `rx_bit` in 1: bus level, where 0 is dominant and 1 is recessive. Sampled only on `bit_tick`.
- `ack_en` in 1: when 1, the block acknowledges good frames.
- `passive` in 1: node is error-passive. Error flags are then sent recessive.
- `tx_bit` out 1: level this node drives onto the bus. Reset value 1.
- `busy` out 1: a frame is in progress, from SOF until EOF or error end. Reset value 0.
- `frame_valid` out 1: one-cycle pulse. Reset value 0.
- `rx_id` out 11, `rx_rtr` out 1, `rx_dlc` out 4, `rx_data` out 64: last valid frame. Reset value 0.
- `err_stuff`, `err_crc`, `err_form` out 1 each: one-cycle error pulses. Reset value 0.

## Operation
- The FSM advances only on `bit_tick`. States:
  - WAIT_IDLE: count consecutive recessive bits; any dominant bit clears the count. After 11, go to IDLE.
  - IDLE: a dominant bit is SOF; go to ARB.
  - ARB: 11 ID bits MSB first, then RTR.
  - CTRL: IDE, r0, DLC[3:0].
  - DATA: 8 × min(DLC,8) bits. Skipped when RTR=1 or DLC=0.
  - CRC: 15 bits.
  - CRC_DEL, ACK, ACK_DEL.
  - EOF: 7 bits.
  - ERRFLAG: 6 bits.
  - Then back to WAIT_IDLE.
- Destuffing covers SOF through the last CRC bit.
  - A run counter tracks consecutive equal bits, and stuff bits count toward it.
  - After 5 equal bits, the next bit is a stuff bit and is discarded. If it equals the previous bit, raise `err_stuff`.
  - The discarded stuff bit starts a new run of length 1.
- CRC register:
  - Cleared at SOF.
  - Updated with each destuffed bit from SOF through the last data bit: nxt = bit ^ crc[14]; crc = crc << 1; if nxt, crc ^= CRC_POLY.
  - The 15 received CRC bits, MSB first, are compared with the register.
- Form checks. Each of these raises `err_form`:
  - IDE=1 (extended frames are unsupported).
  - CRC_DEL=0.
  - ACK_DEL=0.
  - Any EOF bit =0.
- CRC mismatch raises `err_crc`, evaluated on the CRC_DEL tick. If CRC_DEL is also 0, only `err_form` is raised.
- Each error pulses exactly one `err_*` line, then the FSM enters ERRFLAG.
  - During ERRFLAG, `tx_bit` = `passive` for 6 bit times, then returns to 1.
  - Bus-level errors seen during ERRFLAG are ignored.
- ACK:
  - If `ack_en`=1, the CRC matches and CRC_DEL=1, then `tx_bit`=0 for the ACK bit time.
  - The ACK slot level itself is not checked.
- On the 7th EOF bit:
  - Load the `rx_*` registers.
  - Pulse `frame_valid`.
- `rx_data` layout:
  - The first received byte occupies [63:56], MSB first.
  - Unreceived bytes read 0.
  - `rx_dlc` reports the raw DLC, even when the value is 9..15.
- `rx_*` registers hold their values until the next valid frame. Error frames never alter them.
- `busy` is 1 from the SOF tick through the end of EOF or ERRFLAG.
- `rst_n` low mid-frame:
  - All outputs take their reset values immediately.
  - The FSM enters WAIT_IDLE.
  - `tx_bit`=1 with no glitch to 0.

## Timing
- All outputs are registered.
- Latency: each output updates on the clk edge after the `bit_tick` that samples the decisive bit.
  - `err_*` pulse 1 clk after the offending tick.
  - `frame_valid` pulses 1 clk after the 7th EOF tick.
- ACK drive: `tx_bit` falls 1 clk after the CRC_DEL tick and rises 1 clk after the ACK tick.
- Error flag: `tx_bit` falls 1 clk after the error tick, when `passive`=0. It rises 1 clk after the 6th subsequent tick.
- `ack_en` and `passive` are sampled on the tick that starts the driven bit.
- Minimum frame length is 44 ticks (SOF to EOF, no stuffing, DLC=0). Back-to-back frames need 11 recessive ticks in between.

## Test plan
- **Valid 1-byte data frame.**
  - Stimulus: ID=0x123, RTR=0, DLC=1, data=0xA5, bench-model CRC, stuff bits inserted, `ack_en`=1.
  - Required: `tx_bit`=0 for exactly the ACK bit; `frame_valid` pulses once; rx_id=0x123, rx_dlc=1, rx_data=64'hA500_0000_0000_0000; no `err_*`.
- **Stuffing stress.**
  - Stimulus: ID=0x000, DLC=8, data=all 0xFF, which forces many stuff bits.
  - Required: valid frame, rx_data=64'hFFFF_FFFF_FFFF_FFFF. Then with 6 consecutive dominant bits injected in the ID, `err_stuff` pulses and `tx_bit`=0 for 6 ticks.
- **CRC corruption.**
  - Stimulus: flip 1 data bit of the first scenario's frame.
  - Required: no ACK; `err_crc` pulses 1 clk after the CRC_DEL tick; `rx_*` registers keep their prior values.
- **Form errors with passive flag.**
  - Stimulus: RTR frame ID=0x7FF with DLC=4 and no data, then EOF bit 3 forced dominant, `passive`=1.
  - Required: `err_form` pulses; `tx_bit` stays 1; no `frame_valid`.
- **Idle integration and reset.**
  - Stimulus: assert SOF after only 10 recessive bits post-reset.
  - Required: the frame is ignored (`busy`=0).
  - Stimulus: assert `rst_n`=0 mid-DATA.
  - Required: all outputs go to reset values asynchronously; the next frame after 11 recessive bits is received correctly.
